// File: rtl/ps2_button_mapper.sv
// Maps hps_io ps2_key events onto NUM_BTN registered button lines through a
// run-time loadable key table; each entry drives its button as level, toggle or timed pulse.
module ps2_button_mapper #(
  parameter int NUM_BTN      = 16,
  parameter int IDX_W        = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1,
  parameter int PULSE_CYCLES = 2400000,
  parameter int CNT_W        = 22
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic [10:0]        ps2_key,
  input  logic               map_we,
  input  logic [IDX_W-1:0]   map_idx,
  input  logic [8:0]         map_code,
  input  logic               map_ext_any,
  input  logic [1:0]         map_mode,
  output logic [NUM_BTN-1:0] btn,
  output logic               evt_valid,
  output logic [NUM_BTN-1:0] evt_hit,
  output logic               evt_pressed
);

  typedef enum logic [1:0] {
    MODE_OFF    = 2'b00,
    MODE_LEVEL  = 2'b01,
    MODE_TOGGLE = 2'b10,
    MODE_PULSE  = 2'b11
  } mode_e;

  typedef struct packed {
    mode_e      mode;
    logic       ext_any;
    logic [8:0] code;
  } entry_t;

  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  entry_t             entry_q [NUM_BTN];
  entry_t             entry_d [NUM_BTN];
  logic [CNT_W-1:0]   cnt_q   [NUM_BTN];
  logic [CNT_W-1:0]   cnt_d   [NUM_BTN];
  logic [NUM_BTN-1:0] btn_q, btn_d;
  logic [NUM_BTN-1:0] held_q, held_d;
  logic [NUM_BTN-1:0] evt_hit_q, evt_hit_d;
  logic               evt_valid_q, evt_valid_d;
  logic               evt_pressed_q, evt_pressed_d;
  logic               armed_q, armed_d;
  logic               old_state_q, old_state_d;

  logic               key_toggle, key_pressed, key_ext;
  logic [7:0]         key_scan;
  logic               event_det;
  logic [NUM_BTN-1:0] hit;
  logic [NUM_BTN-1:0] fresh_make;
  logic [NUM_BTN-1:0] wr_sel;
  entry_t             wr_entry;

  assign key_toggle  = ps2_key[10];
  assign key_pressed = ps2_key[9];
  assign key_ext     = ps2_key[8];
  assign key_scan    = ps2_key[7:0];

  // Matching always uses the registered (pre-write) table, so a write landing on
  // the same edge as an event still reports that event against the old entry.
  always_comb begin
    // NOTE: every signal gets a default before any conditional assignment, so no latch is inferred.
    hit        = '0;
    fresh_make = '0;
    wr_sel     = '0;
    wr_entry   = '{mode: mode_e'(map_mode), ext_any: map_ext_any, code: map_code};
    event_det  = armed_q && (key_toggle != old_state_q);
    for (int i = 0; i < NUM_BTN; i++) begin
      hit[i] = event_det
            && (entry_q[i].mode != MODE_OFF)
            && (key_scan == entry_q[i].code[7:0])
            && (entry_q[i].ext_any || (key_ext == entry_q[i].code[8]));
      fresh_make[i] = hit[i] && key_pressed && !held_q[i];
      // Indices at or above NUM_BTN never equal any i, so those writes fall away.
      wr_sel[i] = map_we && (map_idx == IDX_W'(i));
    end
  end

  always_comb begin
    entry_d       = entry_q;
    cnt_d         = cnt_q;
    btn_d         = btn_q;
    held_d        = held_q;
    armed_d       = 1'b1;
    old_state_d   = key_toggle;
    evt_valid_d   = |hit;
    evt_hit_d     = hit;
    evt_pressed_d = (|hit) & key_pressed;

    for (int i = 0; i < NUM_BTN; i++) begin
      // Pulse countdown runs independently of events; button drops as it reaches zero.
      if (cnt_q[i] != '0) begin
        cnt_d[i] = cnt_q[i] - CNT_ONE;
        if (cnt_q[i] == CNT_ONE) btn_d[i] = 1'b0;
      end

      if (hit[i]) begin
        held_d[i] = key_pressed;
        case (entry_q[i].mode)
          MODE_LEVEL:  btn_d[i] = key_pressed;
          MODE_TOGGLE: if (fresh_make[i]) btn_d[i] = ~btn_q[i];
          MODE_PULSE: begin
            if (fresh_make[i] && (cnt_q[i] == '0)) begin
              btn_d[i] = 1'b1;
              cnt_d[i] = PULSE_LOAD;
            end
          end
          default: ;
        endcase
      end

      // A table write overrides whatever the event did to this entry's state.
      if (wr_sel[i]) begin
        entry_d[i] = wr_entry;
        btn_d[i]   = 1'b0;
        held_d[i]  = 1'b0;
        cnt_d[i]   = '0;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the key table is a small register array, reset so every entry starts disabled.
      entry_q       <= '{default: '0};
      cnt_q         <= '{default: '0};
      btn_q         <= '0;
      held_q        <= '0;
      evt_hit_q     <= '0;
      evt_valid_q   <= 1'b0;
      evt_pressed_q <= 1'b0;
      armed_q       <= 1'b0;
      old_state_q   <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so all flops update together.
      entry_q       <= entry_d;
      cnt_q         <= cnt_d;
      btn_q         <= btn_d;
      held_q        <= held_d;
      evt_hit_q     <= evt_hit_d;
      evt_valid_q   <= evt_valid_d;
      evt_pressed_q <= evt_pressed_d;
      armed_q       <= armed_d;
      old_state_q   <= old_state_d;
    end
  end

  assign btn         = btn_q;
  assign evt_valid   = evt_valid_q;
  assign evt_hit     = evt_hit_q;
  assign evt_pressed = evt_pressed_q;

endmodule

// File: tb/tb_ps2_button_mapper.sv
// Directed bench for ps2_button_mapper: 12 entries, 8-cycle pulses, hand-derived expectations.
module tb_ps2_button_mapper;

  localparam int NB    = 12;
  localparam int IW    = 4;
  localparam int PULSE = 8;

  logic          clk_sys;
  logic          reset_n;
  logic [10:0]   ps2_key;
  logic          map_we;
  logic [IW-1:0] map_idx;
  logic [8:0]    map_code;
  logic          map_ext_any;
  logic [1:0]    map_mode;
  logic [NB-1:0] btn;
  logic          evt_valid;
  logic [NB-1:0] evt_hit;
  logic          evt_pressed;

  int tests_run    = 0;
  int tests_failed = 0;

  ps2_button_mapper #(
    .NUM_BTN      (NB),
    .IDX_W        (IW),
    .PULSE_CYCLES (PULSE),
    .CNT_W        (4)
  ) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .ps2_key     (ps2_key),
    .map_we      (map_we),
    .map_idx     (map_idx),
    .map_code    (map_code),
    .map_ext_any (map_ext_any),
    .map_mode    (map_mode),
    .btn         (btn),
    .evt_valid   (evt_valid),
    .evt_hit     (evt_hit),
    .evt_pressed (evt_pressed)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic write_entry(input logic [IW-1:0] idx, input logic [8:0] code,
                             input logic ext_any, input logic [1:0] mode);
    map_we      = 1'b1;
    map_idx     = idx;
    map_code    = code;
    map_ext_any = ext_any;
    map_mode    = mode;
    tick();
    map_we      = 1'b0;
  endtask

  task automatic send(input logic pressed, input logic ext, input logic [7:0] code);
    ps2_key = {~ps2_key[10], pressed, ext, code};
    tick();
  endtask

  task automatic test_reset();
    reset_n     = 1'b0;
    ps2_key     = {1'b1, 1'b1, 1'b0, 8'h29};
    map_we      = 1'b0;
    map_idx     = '0;
    map_code    = '0;
    map_ext_any = 1'b0;
    map_mode    = 2'b00;
    repeat (3) tick();
    tests_run++;
    if (btn !== 12'h000) begin
      tests_failed++; $display("FAIL reset_btn: got %h want %h", btn, 12'h000);
    end
    tests_run++;
    if (evt_valid !== 1'b0 || evt_hit !== 12'h000) begin
      tests_failed++; $display("FAIL reset_evt: got valid=%b hit=%h want 0/000", evt_valid, evt_hit);
    end
    reset_n = 1'b1;
    write_entry(4'd0, 9'h029, 1'b0, 2'b01);
    tick();
    tick();
    tests_run++;
    if (evt_valid !== 1'b0 || btn !== 12'h000) begin
      tests_failed++; $display("FAIL arm_no_event: got valid=%b btn=%h want 0/000", evt_valid, btn);
    end
    ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h29};
    #1;
    tests_run++;
    if (btn !== 12'h000) begin
      tests_failed++; $display("FAIL pre_edge_btn: got %h want %h", btn, 12'h000);
    end
    tick();
    tests_run++;
    if (btn !== 12'h001 || evt_valid !== 1'b1 || evt_hit !== 12'h001 || evt_pressed !== 1'b1) begin
      tests_failed++;
      $display("FAIL first_make: got btn=%h valid=%b hit=%h pressed=%b want 001/1/001/1",
               btn, evt_valid, evt_hit, evt_pressed);
    end
    tick();
    tests_run++;
    if (evt_valid !== 1'b0 || btn !== 12'h001) begin
      tests_failed++; $display("FAIL strobe_width: got valid=%b btn=%h want 0/001", evt_valid, btn);
    end
    send(1'b0, 1'b0, 8'h29);
    tests_run++;
    if (btn !== 12'h000 || evt_pressed !== 1'b0 || evt_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL first_break: got btn=%h pressed=%b valid=%b want 000/0/1", btn, evt_pressed, evt_valid);
    end
  endtask

  task automatic test_ext_any();
    write_entry(4'd1, 9'h075, 1'b1, 2'b01);
    send(1'b1, 1'b1, 8'h75);
    tests_run++;
    if (btn !== 12'h002 || evt_hit !== 12'h002) begin
      tests_failed++; $display("FAIL ext_any_make: got btn=%h hit=%h want 002/002", btn, evt_hit);
    end
    send(1'b0, 1'b0, 8'h75);
    tests_run++;
    if (btn !== 12'h000 || evt_hit !== 12'h002) begin
      tests_failed++; $display("FAIL ext_any_break: got btn=%h hit=%h want 000/002", btn, evt_hit);
    end
    write_entry(4'd1, 9'h075, 1'b0, 2'b01);
    send(1'b1, 1'b1, 8'h75);
    tests_run++;
    if (evt_valid !== 1'b0 || evt_hit !== 12'h000 || btn !== 12'h000) begin
      tests_failed++;
      $display("FAIL ext_strict_miss: got valid=%b hit=%h btn=%h want 0/000/000", evt_valid, evt_hit, btn);
    end
    send(1'b1, 1'b0, 8'h75);
    tests_run++;
    if (btn !== 12'h002 || evt_hit !== 12'h002) begin
      tests_failed++; $display("FAIL ext_strict_hit: got btn=%h hit=%h want 002/002", btn, evt_hit);
    end
    send(1'b0, 1'b0, 8'h75);
  endtask

  task automatic test_pulse_shared();
    write_entry(4'd2, 9'h005, 1'b0, 2'b11);
    write_entry(4'd3, 9'h005, 1'b0, 2'b11);
    send(1'b1, 1'b0, 8'h05);
    tests_run++;
    if (btn !== 12'h00C || evt_hit !== 12'h00C) begin
      tests_failed++; $display("FAIL pulse_start: got btn=%h hit=%h want 00C/00C", btn, evt_hit);
    end
    for (int k = 2; k <= PULSE + 1; k++) begin
      if (k == 2) ps2_key = {~ps2_key[10], 1'b0, 1'b0, 8'h05};
      if (k == 4) ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h05};
      tick();
      tests_run++;
      if (btn !== ((k <= PULSE) ? 12'h00C : 12'h000)) begin
        tests_failed++;
        $display("FAIL pulse_cycle_%0d: got %h want %h", k, btn, (k <= PULSE) ? 12'h00C : 12'h000);
      end
      if (k == 2 || k == 4) begin
        tests_run++;
        if (evt_hit !== 12'h00C) begin
          tests_failed++; $display("FAIL pulse_evt_%0d: got hit=%h want 00C", k, evt_hit);
        end
      end
    end
    send(1'b0, 1'b0, 8'h05);
    send(1'b1, 1'b0, 8'h05);
    tests_run++;
    if (btn !== 12'h00C) begin
      tests_failed++; $display("FAIL pulse_retrigger: got %h want %h", btn, 12'h00C);
    end
    repeat (PULSE - 1) tick();
    tests_run++;
    if (btn !== 12'h00C) begin
      tests_failed++; $display("FAIL pulse_retrig_last: got %h want %h", btn, 12'h00C);
    end
    tick();
    tests_run++;
    if (btn !== 12'h000) begin
      tests_failed++; $display("FAIL pulse_retrig_end: got %h want %h", btn, 12'h000);
    end
    send(1'b0, 1'b0, 8'h05);
  endtask

  task automatic test_toggle_typematic();
    logic [2:0] pressed_seq;
    logic [NB-1:0] want_seq [6];
    pressed_seq = 3'b111;
    want_seq = '{12'h010, 12'h010, 12'h010, 12'h010, 12'h000, 12'h000};
    write_entry(4'd4, 9'h01C, 1'b0, 2'b10);
    for (int k = 0; k < 6; k++) begin
      if (k < 3)       send(pressed_seq[k], 1'b0, 8'h1C);
      else if (k == 3) send(1'b0, 1'b0, 8'h1C);
      else if (k == 4) send(1'b1, 1'b0, 8'h1C);
      else             send(1'b0, 1'b0, 8'h1C);
      tests_run++;
      if (btn !== want_seq[k] || evt_hit !== 12'h010) begin
        tests_failed++;
        $display("FAIL toggle_step_%0d: got btn=%h hit=%h want %h/010", k, btn, evt_hit, want_seq[k]);
      end
    end
  endtask

  task automatic test_write_collision();
    map_we      = 1'b1;
    map_idx     = 4'd0;
    map_code    = 9'h029;
    map_ext_any = 1'b0;
    map_mode    = 2'b00;
    ps2_key     = {~ps2_key[10], 1'b1, 1'b0, 8'h29};
    tick();
    map_we      = 1'b0;
    tests_run++;
    if (evt_valid !== 1'b1 || evt_hit !== 12'h001 || btn !== 12'h000) begin
      tests_failed++;
      $display("FAIL collision: got valid=%b hit=%h btn=%h want 1/001/000", evt_valid, evt_hit, btn);
    end
    send(1'b1, 1'b0, 8'h29);
    tests_run++;
    if (evt_valid !== 1'b0 || evt_hit !== 12'h000 || btn !== 12'h000) begin
      tests_failed++;
      $display("FAIL disabled_entry: got valid=%b hit=%h btn=%h want 0/000/000", evt_valid, evt_hit, btn);
    end
    write_entry(4'd13, 9'h029, 1'b0, 2'b01);
    send(1'b1, 1'b0, 8'h29);
    tests_run++;
    if (evt_valid !== 1'b0 || btn !== 12'h000) begin
      tests_failed++; $display("FAIL idx_out_of_range: got valid=%b btn=%h want 0/000", evt_valid, btn);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]    seq_pressed;
    logic [NB-1:0] seq_btn [3];
    seq_pressed = 3'b101;
    seq_btn     = '{12'h020, 12'h000, 12'h020};
    write_entry(4'd5, 9'h033, 1'b0, 2'b01);
    for (int k = 0; k < 3; k++) begin
      send(seq_pressed[k], 1'b0, 8'h33);
      tests_run++;
      if (btn !== seq_btn[k] || evt_valid !== 1'b1 || evt_pressed !== seq_pressed[k]) begin
        tests_failed++;
        $display("FAIL b2b_%0d: got btn=%h valid=%b pressed=%b want %h/1/%b",
                 k, btn, evt_valid, evt_pressed, seq_btn[k], seq_pressed[k]);
      end
    end
    tick();
    tests_run++;
    if (evt_valid !== 1'b0 || btn !== 12'h020) begin
      tests_failed++; $display("FAIL b2b_idle: got valid=%b btn=%h want 0/020", evt_valid, btn);
    end
    write_entry(4'd5, 9'h033, 1'b0, 2'b01);
    tests_run++;
    if (btn !== 12'h000) begin
      tests_failed++; $display("FAIL write_clears_btn: got %h want %h", btn, 12'h000);
    end
  endtask

  initial begin
    test_reset();
    test_ext_any();
    test_pulse_shared();
    test_toggle_typematic();
    test_write_collision();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
